// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one byte-serial double-precision multiplier between
// NUM_REQ requesters: serialise operands, collect the product, return it.
module fp_mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [64*NUM_REQ-1:0]  REQ_A,
    input  logic [64*NUM_REQ-1:0]  REQ_B,
    output logic [NUM_REQ-1:0]     REQ_READY,
    output logic [NUM_REQ-1:0]     RSP_VALID,
    input  logic [NUM_REQ-1:0]     RSP_READY,
    output logic [63:0]            RSP_DATA,
    output logic                   RSP_ERR,
    output logic                   MUL_ENABLE,
    output logic [7:0]             MUL_DATA_IN,
    input  logic [7:0]             MUL_DATA_OUT,
    input  logic                   MUL_READY,
    output logic                   BUSY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic [2:0]          state_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    grant_reg;
    logic [127:0]        shift_reg;
    logic [63:0]         result_reg;
    logic                err_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [NUM_REQ-1:0]  req_ready_reg;

    logic [63:0]         req_a_arr [NUM_REQ];
    logic [63:0]         req_b_arr [NUM_REQ];
    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_a_arr[gi] = REQ_A[64*gi +: 64];
            assign req_b_arr[gi] = REQ_B[64*gi +: 64];
            assign RSP_VALID[gi] = (state_reg == S_RESP) && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && REQ_VALID[wrap_idx(ptr_reg, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr_reg, k);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            shift_reg     <= '0;
            result_reg    <= '0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            req_ready_reg <= '0;
        end else begin
            req_ready_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        req_ready_reg <= NUM_REQ'(1) << grant_idx;
                        grant_reg     <= grant_idx;
                        ptr_reg       <= wrap_idx(grant_idx, 1);
                        shift_reg     <= {req_b_arr[grant_idx], req_a_arr[grant_idx]};
                        result_reg    <= '0;
                        err_reg       <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= S_SEND;
                    end
                end
                S_SEND: begin
                    shift_reg <= {8'h00, shift_reg[127:8]};
                    if (cnt_reg == CNT_W'(15)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_WAIT: begin
                    // READY and result byte 0 arrive together.
                    if (MUL_READY) begin
                        result_reg[7:0] <= MUL_DATA_OUT;
                        cnt_reg         <= CNT_W'(1);
                        state_reg       <= S_RECV;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        err_reg    <= 1'b1;
                        result_reg <= QNAN;
                        cnt_reg    <= '0;
                        state_reg  <= S_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RECV: begin
                    if (MUL_READY) begin
                        result_reg[{cnt_reg[2:0], 3'b000} +: 8] <= MUL_DATA_OUT;
                        if (cnt_reg == CNT_W'(7)) begin
                            cnt_reg   <= '0;
                            state_reg <= S_GAP;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        err_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (RSP_READY[grant_reg]) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign REQ_READY   = req_ready_reg;
    assign MUL_ENABLE  = (state_reg == S_SEND);
    assign MUL_DATA_IN = (state_reg == S_SEND) ? shift_reg[7:0] : 8'h00;
    assign RSP_DATA    = result_reg;
    assign RSP_ERR     = err_reg;
    assign BUSY        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: behavioural byte-serial multiplier stub plus a
// round-robin reference model; directed table, corner sequences, random ops.
module tb_fp_mult_arbiter;

    localparam int NR = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [1:0]    REQ_VALID = '0;
    logic [127:0]  REQ_A;
    logic [127:0]  REQ_B;
    logic [1:0]    REQ_READY;
    logic [1:0]    RSP_VALID;
    logic [1:0]    RSP_READY = '0;
    logic [63:0]   RSP_DATA;
    logic          RSP_ERR;
    logic          MUL_ENABLE;
    logic [7:0]    MUL_DATA_IN;
    logic [7:0]    MUL_DATA_OUT = '0;
    logic          MUL_READY = 1'b0;
    logic          BUSY;

    logic [63:0]   op_a [NR];
    logic [63:0]   op_b [NR];
    assign REQ_A = {op_a[1], op_a[0]};
    assign REQ_B = {op_b[1], op_b[0]};

    fp_mult_arbiter #(.NUM_REQ(NR), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .MUL_ENABLE(MUL_ENABLE), .MUL_DATA_IN(MUL_DATA_IN), .MUL_DATA_OUT(MUL_DATA_OUT),
        .MUL_READY(MUL_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int ptr_model = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The stub multiplier's arithmetic: IEEE product, with its own quirky
    // encoding for inf*0.
    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        bit a_inf, b_inf, a_zero, b_zero;
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
        a_zero = (a[62:0] == 63'd0);
        b_zero = (b[62:0] == 63'd0);
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 64'h7FF0_0000_0000_0001;
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rnd_fp();
        return {1'($urandom), 11'($urandom_range(32'h3C0, 32'h43F)), 52'({$urandom, $urandom})};
    endfunction

    // Byte-serial multiplier stub, driven on the falling edge.
    bit           stub_hang = 1'b0;
    int           stub_lat = 0;
    int           last_en_cnt = 0;
    logic [127:0] last_bits = '0;
    logic [127:0] sb_bits = '0;
    logic [63:0]  sb_word = '0;
    int           sb_cnt = 0, sb_phase = 0, sb_dly = 0, sb_idx = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            sb_cnt = 0; sb_phase = 0; MUL_READY = 1'b0; MUL_DATA_OUT = 8'h00;
        end else begin
            if (sb_phase == 0) begin
                if (MUL_ENABLE) begin
                    sb_bits = {MUL_DATA_IN, sb_bits[127:8]};
                    sb_cnt++;
                end else if (sb_cnt != 0) begin
                    last_en_cnt = sb_cnt;
                    last_bits   = sb_bits;
                    sb_cnt      = 0;
                    sb_word     = fmul(sb_bits[63:0], sb_bits[127:64]);
                    sb_dly      = stub_lat;
                    if (!stub_hang) sb_phase = 1;
                end
            end else if (sb_phase == 2) begin
                if (sb_idx == 8) begin
                    MUL_READY = 1'b0; MUL_DATA_OUT = 8'h00; sb_phase = 0;
                end else begin
                    MUL_DATA_OUT = sb_word[sb_idx*8 +: 8];
                    sb_idx++;
                end
            end
            if (sb_phase == 1) begin
                if (sb_dly == 0) begin
                    MUL_READY = 1'b1; MUL_DATA_OUT = sb_word[7:0]; sb_idx = 1; sb_phase = 2;
                end else begin
                    sb_dly--;
                end
            end
        end
    end

    // One operation end to end; expected grant comes from the round-robin model.
    task automatic run_op(input logic [1:0] mask, input bit hold, input int rsp_delay,
                          input bit use_exp, input logic [63:0] exp_data);
        int g, n;
        bit seen, bad;
        logic [1:0]  oh;
        logic [63:0] exp;
        logic        exp_err;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            if (g < 0 && mask[(ptr_model + k) % NR]) g = (ptr_model + k) % NR;
        end
        ptr_model = (g + 1) % NR;
        oh = 2'(1 << g);
        exp_err = stub_hang;
        exp = use_exp ? exp_data : (stub_hang ? 64'h7FF8_0000_0000_0000 : fmul(op_a[g], op_b[g]));

        REQ_VALID = mask;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (REQ_READY != 2'b00) seen = 1'b1;
        end
        chk("req_ready", REQ_READY, oh);
        if (!hold) REQ_VALID = 2'b00;

        n = 0; bad = 1'b0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge CLK);
            n++;
            if (RSP_VALID != 2'b00) seen = 1'b1;
            else if (REQ_READY != 2'b00) bad = 1'b1;
        end
        chk("latency", n, stub_hang ? 82 : 26 + stub_lat);
        chk("rsp_valid", RSP_VALID, oh);
        chk("rsp_data", RSP_DATA, exp);
        chk("rsp_err", RSP_ERR, exp_err);

        RSP_READY = ~oh;
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== oh || RSP_DATA !== exp || RSP_ERR !== exp_err ||
                BUSY !== 1'b1 || REQ_READY != 2'b00) bad = 1'b1;
        end
        RSP_READY = oh;
        @(negedge CLK);
        RSP_READY = 2'b00;
        chk("rsp_drop", {RSP_VALID, BUSY}, 0);
        chk("hold_stable", bad, 0);
        chk("en_cycles", last_en_cnt, 16);
        chk("mul_bytes", last_bits, {op_b[g], op_a[g]});
        $display("op grant=%0d a=%h b=%h rsp=%h err=%0d lat=%0d", g, op_a[g], op_b[g], RSP_DATA, RSP_ERR, n);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        ptr_model = 0;
    endtask

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs [4];
    bit   bad_rst;

    initial begin
        vecs[0] = '{0, 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000};
        vecs[1] = '{1, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h7FF0_0000_0000_0001};
        vecs[2] = '{0, 64'hBFF0_0000_0000_0000, 64'h4010_0000_0000_0000, 64'hC010_0000_0000_0000};
        vecs[3] = '{1, 64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000};
        for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, MUL_ENABLE, MUL_DATA_IN, BUSY}, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed vectors, one requester at a time.
        for (int i = 0; i < 4; i++) begin
            op_a[vecs[i].idx] = vecs[i].a;
            op_b[vecs[i].idx] = vecs[i].b;
            stub_lat = 3 * i;
            run_op(2'(1 << vecs[i].idx), 1'b0, 1, 1'b1, vecs[i].prod);
        end

        // Hung multiplier, then a normal operation.
        stub_hang = 1'b1;
        op_a[0] = rnd_fp(); op_b[0] = rnd_fp();
        run_op(2'b01, 1'b0, 0, 1'b0, '0);
        stub_hang = 1'b0;
        stub_lat = 11;
        run_op(2'b01, 1'b0, 0, 1'b0, '0);

        // Long response stall with the other requester waiting.
        for (int i = 0; i < NR; i++) begin op_a[i] = rnd_fp(); op_b[i] = rnd_fp(); end
        stub_lat = 5;
        run_op(2'b11, 1'b1, 20, 1'b0, '0);
        run_op(2'b11, 1'b0, 0, 1'b0, '0);

        // Both requesters held from reset: grants alternate.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NR; i++) begin op_a[i] = rnd_fp(); op_b[i] = rnd_fp(); end
            stub_lat = $urandom_range(0, 11);
            run_op(2'b11, (k < 3), 0, 1'b0, '0);
        end

        // Random masks, operands, multiplier latency and response stalls.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NR; i++) begin op_a[i] = rnd_fp(); op_b[i] = rnd_fp(); end
            stub_lat = $urandom_range(0, 11);
            run_op(2'($urandom_range(1, 3)), 1'b0, $urandom_range(0, 3), 1'b0, '0);
        end

        // Reset on the 8th SEND cycle, then a fresh request.
        op_a[0] = vecs[0].a; op_b[0] = vecs[0].b;
        REQ_VALID = 2'b01;
        begin
            bit seen_rr;
            seen_rr = 1'b0;
            for (int i = 0; i < 50 && !seen_rr; i++) begin
                @(negedge CLK);
                if (REQ_READY[0]) seen_rr = 1'b1;
            end
            chk("abort_grant", seen_rr, 1);
        end
        REQ_VALID = 2'b00;
        repeat (7) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_reset", {REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, MUL_ENABLE, MUL_DATA_IN, BUSY}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        ptr_model = 0;
        bad_rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (RSP_VALID != 2'b00 || BUSY !== 1'b0) bad_rst = 1'b1;
        end
        chk("no_rsp_after_abort", bad_rst, 0);
        stub_lat = 2;
        run_op(2'b01, 1'b0, 0, 1'b1, vecs[0].prod);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
